// File: rtl/display_pkg.sv
// Shared constants, FSM state type and cell-packing helper for the character display writer.
package display_pkg;

    localparam logic [7:0] CH_BS       = 8'h08;
    localparam logic [7:0] CH_LF       = 8'h0A;
    localparam logic [7:0] CH_FF       = 8'h0C;
    localparam logic [7:0] CH_CR       = 8'h0D;
    localparam logic [7:0] CH_SPACE    = 8'h20;
    localparam logic [7:0] CH_PRINT_LO = 8'h20;
    localparam logic [7:0] CH_PRINT_HI = 8'h7E;

    // attr layout {1'b0, fg[2:0], 1'b0, bg[2:0]}, matching the display's RGB mode.
    localparam int         ATTR_FG_LSB  = 4;
    localparam int         ATTR_BG_LSB  = 0;
    localparam int         ATTR_COLOR_W = 3;
    localparam logic [7:0] ATTR_COLOR   = 8'((1 << ATTR_COLOR_W) - 1);
    localparam logic [7:0] ATTR_MASK    = (ATTR_COLOR << ATTR_FG_LSB) | (ATTR_COLOR << ATTR_BG_LSB);

    typedef enum logic [1:0] {
        IDLE,
        CLR_ROW,
        CLR_SCREEN
    } state_t;

    function automatic logic [15:0] make_cell(input logic [7:0] a, input logic [7:0] ch);
        return {a & ATTR_MASK, ch};
    endfunction

endpackage

// File: rtl/display_console_writer.sv
// Text-console front end: consumes a byte stream, tracks a cursor and writes VRAM cells,
// clearing each newly entered row and the whole screen on reset or form feed.
module display_console_writer
    import display_pkg::*;
#(
    parameter int COLS           = 40,
    parameter int ROWS           = 30,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  attr,
    output logic [11:0] waddr,
    output logic [15:0] wdata,
    output logic        we,
    output logic [6:0]  cursor_x,
    output logic [4:0]  cursor_y,
    output logic        busy
);

    localparam logic [11:0] COLS_A    = 12'(COLS);
    localparam logic [11:0] LAST_CELL = 12'(ROWS * COLS - 1);
    localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
    localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);

    state_t      state;
    logic [11:0] row_base;
    logic [11:0] clr_addr;
    logic [11:0] clr_end;
    logic [7:0]  attr_q;

    logic        accept;
    logic        printable;
    logic        new_row;
    logic [11:0] cell_addr;
    logic [4:0]  next_y;
    logic [11:0] next_base;

    // Handshake: a byte transfers on a rising edge where in_valid and in_ready are both
    // high; in_ready is only ever high in IDLE, and in_data must be held until taken.
    assign accept    = in_valid & in_ready;
    assign printable = (in_data >= CH_PRINT_LO) && (in_data <= CH_PRINT_HI);
    assign cell_addr = row_base + {5'b0, cursor_x};
    assign new_row   = accept && ((printable && cursor_x == LAST_COL) || in_data == CH_LF);

    always_comb begin
        next_y    = cursor_y + 5'd1;
        next_base = row_base + COLS_A;
        if (cursor_y == LAST_ROW) begin
            next_y    = 5'd0;
            next_base = 12'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CLEAR_ON_RESET ? CLR_SCREEN : IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            we       <= 1'b0;
            waddr    <= 12'd0;
            wdata    <= 16'd0;
            cursor_x <= 7'd0;
            cursor_y <= 5'd0;
            row_base <= 12'd0;
            clr_addr <= 12'd0;
            clr_end  <= LAST_CELL;
            attr_q   <= attr;
        end else begin
            case (state)
                IDLE: begin
                    we       <= 1'b0;
                    busy     <= 1'b0;
                    in_ready <= 1'b1;
                    if (accept) begin
                        if (printable) begin
                            we       <= 1'b1;
                            waddr    <= cell_addr;
                            wdata    <= make_cell(attr, in_data);
                            cursor_x <= (cursor_x == LAST_COL) ? 7'd0 : cursor_x + 7'd1;
                        end else begin
                            case (in_data)
                                CH_CR: cursor_x <= 7'd0;
                                CH_LF: cursor_x <= 7'd0;
                                CH_BS: begin
                                    if (cursor_x != 7'd0) begin
                                        cursor_x <= cursor_x - 7'd1;
                                        we       <= 1'b1;
                                        waddr    <= cell_addr - 12'd1;
                                        wdata    <= make_cell(attr, CH_SPACE);
                                    end
                                end
                                CH_FF: begin
                                    cursor_x <= 7'd0;
                                    cursor_y <= 5'd0;
                                    row_base <= 12'd0;
                                    state    <= CLR_SCREEN;
                                    clr_addr <= 12'd0;
                                    clr_end  <= LAST_CELL;
                                    attr_q   <= attr;
                                    in_ready <= 1'b0;
                                    busy     <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                        // Entering a new row (wrap or LF) blanks it before more text lands.
                        if (new_row) begin
                            cursor_y <= next_y;
                            row_base <= next_base;
                            state    <= CLR_ROW;
                            clr_addr <= next_base;
                            clr_end  <= next_base + COLS_A - 12'd1;
                            attr_q   <= attr;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end
                    end
                end
                CLR_ROW, CLR_SCREEN: begin
                    we       <= 1'b1;
                    waddr    <= clr_addr;
                    wdata    <= make_cell(attr_q, CH_SPACE);
                    busy     <= 1'b1;
                    clr_addr <= clr_addr + 12'd1;
                    in_ready <= 1'b0;
                    // Ready rises with the final clear write so the next byte's write follows it directly.
                    if (clr_addr == clr_end) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    we       <= 1'b0;
                    busy     <= 1'b0;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_console_writer.sv
// Bench for display_console_writer: a cursor model pushes expected VRAM writes, a negedge
// monitor pops and compares them, and directed checks cover cursor, ready and busy timing.
module tb_display_console_writer;

    localparam int COLS = 40;
    localparam int ROWS = 30;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  attr;
    logic [11:0] waddr;
    logic [15:0] wdata;
    logic        we;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic        busy;

    logic [27:0] exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int wr_count = 0;
    int last_we_cyc = 0;
    int prev_we_cyc = 0;
    int mx = 0;
    int my = 0;

    display_console_writer #(.COLS(COLS), .ROWS(ROWS), .CLEAR_ON_RESET(1'b1)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .attr     (attr),
        .waddr    (waddr),
        .wdata    (wdata),
        .we       (we),
        .cursor_x (cursor_x),
        .cursor_y (cursor_y),
        .busy     (busy)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // scoreboard model
    task automatic push_write(input int addr, input logic [7:0] ch);
        logic [11:0] a;
        a = 12'(addr);
        exp_q.push_back({a, attr, ch});
    endtask

    task automatic push_clear(input int base, input int n);
        for (int i = 0; i < n; i++) push_write(base + i, 8'h20);
    endtask

    task automatic adv_row();
        my = (my == ROWS - 1) ? 0 : my + 1;
        push_clear(my * COLS, COLS);
    endtask

    task automatic model(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            push_write(my * COLS + mx, b);
            if (mx == COLS - 1) begin
                mx = 0;
                adv_row();
            end else begin
                mx++;
            end
        end else if (b == 8'h0D) begin
            mx = 0;
        end else if (b == 8'h0A) begin
            mx = 0;
            adv_row();
        end else if (b == 8'h08) begin
            if (mx > 0) begin
                mx--;
                push_write(my * COLS + mx, 8'h20);
            end
        end else if (b == 8'h0C) begin
            mx = 0;
            my = 0;
            push_clear(0, ROWS * COLS);
        end
    endtask

    // monitor
    always @(negedge clk) begin
        logic [27:0] e;
        cyc++;
        if (!reset && we) begin
            wr_count++;
            prev_we_cyc = last_we_cyc;
            last_we_cyc = cyc;
            check("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("waddr", 32'(waddr), 32'(e[27:16]));
                check("wdata", 32'(wdata), 32'(e[15:0]));
            end
        end
    end

    // driver tasks
    task automatic send(input logic [7:0] b);
        model(b);
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 5000 && !in_ready; i++) @(negedge clk);
        check("send_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_printable();
        logic [7:0] b;
        b = 8'($urandom_range(32, 126));
        send(b);
    endtask

    task automatic drain();
        for (int i = 0; i < 5000 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic count_screen_clear();
        int busy_cnt;
        busy_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (in_ready) break;
        end
        check("clear_busy_cycles", 32'(busy_cnt), 32'd1200);
        check("clear_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int w0;
        int low_cnt;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        attr     = 8'h07;
        repeat (3) @(negedge clk);
        check("rst_we", 32'(we), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cursor_x", 32'(cursor_x), 32'd0);
        check("rst_cursor_y", 32'(cursor_y), 32'd0);
        check("rst_waddr", 32'(waddr), 32'd0);
        check("rst_wdata", 32'(wdata), 32'd0);

        reset = 1'b0;
        push_clear(0, ROWS * COLS);
        count_screen_clear();
        check("post_clear_x", 32'(cursor_x), 32'd0);
        check("post_clear_y", 32'(cursor_y), 32'd0);
        drain();

        // back-to-back "HI"
        attr = 8'h71;
        send(8'h48);
        send(8'h49);
        drain();
        check("hi_consecutive", 32'(last_we_cyc - prev_we_cyc), 32'd1);
        check("hi_cursor_x", 32'(cursor_x), 32'd2);

        // full row from (0,3) then wrap into row 4
        attr = 8'h52;
        send(8'h0D);
        for (int i = 0; i < 3; i++) send(8'h0A);
        drain();
        check("row3_y", 32'(cursor_y), 32'd3);
        for (int i = 0; i < COLS; i++) send_printable();
        check("wrap_x", 32'(cursor_x), 32'd0);
        check("wrap_y", 32'(cursor_y), 32'd4);
        low_cnt = 0;
        while (!in_ready && low_cnt < 200) begin
            low_cnt++;
            @(negedge clk);
        end
        check("row_clear_ready_low", 32'(low_cnt), 32'd40);
        drain();

        // LF on last row wraps to row 0
        for (int i = 0; i < 25; i++) send(8'h0A);
        drain();
        check("y_last_row", 32'(cursor_y), 32'd29);
        send(8'h0A);
        drain();
        check("lf_wrap_y", 32'(cursor_y), 32'd0);
        for (int i = 0; i < 17; i++) send_printable();
        drain();
        check("pre_cr_x", 32'(cursor_x), 32'd17);
        w0 = wr_count;
        send(8'h0D);
        repeat (3) @(negedge clk);
        check("cr_no_write", 32'(wr_count - w0), 32'd0);
        check("cr_x", 32'(cursor_x), 32'd0);

        // backspace at (5,2) and at column 0
        send(8'h0A);
        send(8'h0A);
        for (int i = 0; i < 5; i++) send_printable();
        drain();
        check("pre_bs_y", 32'(cursor_y), 32'd2);
        w0 = wr_count;
        send(8'h08);
        drain();
        check("bs_one_write", 32'(wr_count - w0), 32'd1);
        check("bs_x", 32'(cursor_x), 32'd4);
        send(8'h0D);
        w0 = wr_count;
        send(8'h08);
        repeat (3) @(negedge clk);
        check("bs_x0_no_write", 32'(wr_count - w0), 32'd0);
        check("bs_x0_x", 32'(cursor_x), 32'd0);
        check("bs_x0_y", 32'(cursor_y), 32'd2);

        // ignored control byte
        w0 = wr_count;
        send(8'h7F);
        repeat (3) @(negedge clk);
        check("ignored_no_write", 32'(wr_count - w0), 32'd0);

        // form feed, then reset 100 cycles into the clear
        for (int i = 0; i < 3; i++) send_printable();
        send(8'h0C);
        check("ff_busy", 32'(busy), 32'd1);
        check("ff_x", 32'(cursor_x), 32'd0);
        check("ff_y", 32'(cursor_y), 32'd0);
        repeat (99) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        exp_q.delete();
        check("abort_we", 32'(we), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        mx    = 0;
        my    = 0;
        reset = 1'b0;
        push_clear(0, ROWS * COLS);
        count_screen_clear();
        drain();

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/display_console_writer.md
Name: display_console_writer

Overview:
- Streaming text-console front end that writes the character display's VRAM through its write port (waddr/wdata/we).
- Accepts one byte per valid/ready handshake and keeps a cursor.
- Interprets CR, LF, BS and FF; auto-wraps at end of line and clears each new row on entry, so a wrapped screen never shows stale text.
- Sits between a CPU/UART byte source and the display, in the display's pixel-clock domain (wclk = clk).

Parameters:
- COLS, 40, characters per row (40 for the wide display mode, 80 for narrow).
- ROWS, 30, rows per screen.
- CLEAR_ON_RESET, 1, when 1, reset starts a full-screen clear before accepting input.

Ports:
- clk  input  1  display clock; also drives the display's wclk.
- reset  input  1  synchronous, active-high reset.
- in_data  input  8  byte to print or control code.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a byte this cycle.
- attr  input  8  {1'b0, fg[2:0], 1'b0, bg[2:0]}; sampled on accept and on clear start.
- waddr  output  12  VRAM cell address = row*COLS + col.
- wdata  output  16  {attr, char}.
- we  output  1  VRAM write strobe, one cell per cycle.
- cursor_x  output  7  current column, 0..COLS-1.
- cursor_y  output  5  current row, 0..ROWS-1.
- busy  output  1  a row clear or screen clear is in progress.

Behaviour:
- Clock and reset:
  - One clock, clk; reset is synchronous and active-high.
  - Reset values: we=0, in_ready=0, busy=0, cursor_x=0, cursor_y=0, waddr=0, wdata=0.
  - Cycle after reset deasserts: state = CLR_SCREEN if CLEAR_ON_RESET, else IDLE.
- States:
  - IDLE: in_ready=1; accept = in_valid & in_ready.
  - CLR_ROW: clearing one row.
  - CLR_SCREEN: clearing the whole screen.
- Cursor address:
  - Maintain a row_base register equal to cursor_y*COLS, updated incrementally (+COLS, or 0 on wrap). No multiplier.
  - Cell address = row_base + cursor_x, 12-bit.
- Printable byte (0x20..0x7E) accepted in cycle N:
  - Cycle N+1: we=1, waddr=old address, wdata={attr,in_data}.
  - If cursor_x < COLS-1: cursor_x+1, stay IDLE; back-to-back bytes sustain one write per cycle.
  - If cursor_x == COLS-1: cursor_x=0 and cursor_y=(cursor_y==ROWS-1)?0:cursor_y+1; enter CLR_ROW on the new row.
- 0x0D CR: cursor_x=0; no write.
- 0x0A LF: cursor_x=0; cursor_y advances with wrap as above; enter CLR_ROW on the new row.
- 0x08 BS:
  - If cursor_x>0: cursor_x-1, then write {attr,0x20} at the new position (next cycle).
  - If cursor_x==0: no-op, no write.
- 0x0C FF: cursor to (0,0); enter CLR_SCREEN.
- Any other byte (0x00..0x1F not listed above, 0x7F..0xFF): consumed with no effect.
- CLR_ROW:
  - in_ready=0, busy=1.
  - Writes {attr_latched,0x20} to row_base+0 .. row_base+COLS-1, one per cycle (COLS cycles), then IDLE.
- CLR_SCREEN:
  - in_ready=0, busy=1.
  - Writes the space cell to 0 .. ROWS*COLS-1, one per cycle, then IDLE with cursor (0,0).
- Write outputs:
  - we, waddr and wdata are registered.
  - we is never high for more than one write per cycle and never high in the reset cycle.
- Reset during a clear: the clear is aborted and the reset sequence restarts; no partial write follows the reset cycle.
- in_valid while in_ready=0: the byte is held upstream and not consumed.

Decomposition:
- display_pkg holds:
  - Constants CH_BS=8'h08, CH_LF=8'h0A, CH_FF=8'h0C, CH_CR=8'h0D, CH_SPACE=8'h20.
  - The state enum {IDLE, CLR_ROW, CLR_SCREEN}.
  - The attr bit-layout constants shared with the display's RGB mode.
- No sub-module: a single FSM plus cursor/row_base counters and a clear counter.

Test Plan:
- Reset (CLEAR_ON_RESET=1, COLS=40, ROWS=30) -> busy=1 for 1200 cycles; writes 0x0020|attr<<8 to 0..1199; then in_ready=1, cursor (0,0).
- Stream "HI" back-to-back, attr=0x71 -> we at 0 and 1 on consecutive cycles with wdata 0x7148 then 0x7149; cursor_x=2.
- 40 printable bytes from (0,3) -> last write at waddr 159; cursor (0,4); then 40 clear writes at 160..199; in_ready low for 40 cycles.
- LF at cursor_y=29 -> cursor_y=0, row 0 cleared at addresses 0..39; CR at x=17 -> x=0 with no we.
- BS at (5,2) -> single write of 0x20 at waddr 84, cursor_x=4; BS at x=0 -> no write, cursor unchanged.
- FF mid-line, then reset asserted 100 cycles into the clear -> we=0 the following cycle; the clear restarts from address 0.
